run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Sequences the replica-exchange annealing loop after the host writes a run command through the AXI-Lite bus interface.
- Each iteration has two phases: an optimisation phase, in which all replicas perform one annealing step, then a replica-exchange phase alternating even/odd pairs.
- Drives the `running` status that the host polls, and supports graceful abort.
- Sits between the bus interface (run_write/run_times) and the replica array / exchange unit.

Parameters:
- replica_num, 32, number of replicas; width of opt_done.
- run_times_w, 24, width of the iteration count.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- run_write  in  1  one-cycle pulse: run command from the bus interface.
- run_times  in  run_times_w  iteration count, valid with run_write.
- opt_run  out  1  one-cycle pulse: all replicas start one optimisation step.
- opt_done  in  replica_num  per-replica one-cycle completion pulses.
- exchange_run  out  1  one-cycle pulse: start exchange phase.
- exchange_odd  out  1  exchange pairing: 0 = pairs (0,1),(2,3)…; 1 = pairs (1,2),(3,4)…; stable from exchange_run to exchange_done.
- exchange_done  in  1  one-cycle pulse: exchange phase complete.
- running  out  1  high while a run is in progress.
- iter_count  out  run_times_w  iterations completed in the current/last run.

Behaviour:
- Reset is asynchronous. All outputs are 0: running, opt_run, exchange_run, exchange_odd, iter_count. State = IDLE; done mask = 0; remaining = 0; abort flag = 0.
- States are IDLE, OPT_START, OPT_WAIT, EX_START, EX_WAIT. The state is registered. opt_run = (state==OPT_START) and exchange_run = (state==EX_START), decoded from the state register with no extra delay.
- IDLE:
  - run_write && run_times!=0 → OPT_START.
  - On that transition: load remaining=run_times, iter_count=0, exchange_odd=0, running=1, abort=0.
  - Latency: run_write at cycle t gives running=1 and opt_run=1 at t+1.
  - run_write with run_times==0 in IDLE has no effect.
- OPT_START: one cycle. Clear the done mask. opt_done pulses in this cycle are ignored (replicas cannot respond in 0 cycles). → OPT_WAIT.
- OPT_WAIT:
  - mask |= opt_done every cycle.
  - When (mask|opt_done) is all ones → EX_START. A replica finishing in the same cycle as the last outstanding one counts.
  - Duplicate pulses from one replica are harmless.
- EX_START: one cycle; exchange_run=1. → EX_WAIT.
- EX_WAIT, on exchange_done:
  - Update: iter_count+1, remaining-1, toggle exchange_odd.
  - If remaining==1 or abort==1 → IDLE and running=0 (next cycle). Otherwise → OPT_START.
  - exchange_done in any state other than EX_WAIT is ignored.
- Abort / run_write while busy (state≠IDLE):
  - run_write with run_times==0 sets abort=1. The current iteration completes, then the block returns to IDLE.
  - run_write with run_times≠0 while busy is ignored; remaining is unchanged.
- Re-run: a new run_write in the IDLE cycle right after completion starts a fresh run. iter_count resets only at run start, so it holds the final count while idle.
- Counters do not wrap: remaining≥1 whenever state≠IDLE. The maximum run_times is 2^run_times_w−1.
- Reset mid-run returns the block to IDLE immediately; no pulses are emitted afterwards.

Decomposition:
- In replica_pkg:
  - run_state_t enum {IDLE, OPT_START, OPT_WAIT, EX_START, EX_WAIT}.
  - localparam run_times_w=24, shared with the bus interface's run_times width.
- One natural sub-module: replica_done_mask, which holds the replica_num-bit sticky mask with clear/accumulate and outputs all_done.
- Everything else stays in run_ctrl.

Test Plan:
- Single iteration. run_write, run_times=1 at t. Expect running=1 and opt_run=1 at t+1. Pulse all opt_done at t+5 → exchange_run at t+6 with exchange_odd=0. exchange_done at t+9 → running=0 at t+10, iter_count=1.
- Parity alternation. run_times=3. Expect three opt_run/exchange_run pairs with exchange_odd 0,1,0, then iter_count=3 and running=0.
- Staggered completion. run_times=1. Replicas 0..30 pulse at different cycles, replica 31 last at t+20. Expect exchange_run exactly at t+21 and not earlier. A duplicate pulse from replica 0 causes no early advance.
- Abort. run_times=100. Write run_times=0 during the second OPT_WAIT. Expect that iteration to finish, then iter_count=2 and running=0. A nonzero run_write while busy leaves the final count unaffected.
- Ignored inputs. In IDLE, run_write with run_times=0 → running stays 0. exchange_done and opt_done pulses in IDLE → no state change.
- Reset mid-run. Assert S_AXI_ARESETN=0 during EX_WAIT. Expect all outputs 0 asynchronously. After release there is no exchange_run, and a new run starts cleanly with exchange_odd=0.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types and widths for the replica-exchange annealing control path.
package replica_pkg;

    localparam int run_times_w = 24;

    typedef enum logic [2:0] {
        IDLE,
        OPT_START,
        OPT_WAIT,
        EX_START,
        EX_WAIT
    } run_state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Handshake bundle between the bus interface, run_ctrl and the replica array / exchange unit.
interface run_ctrl_if
    import replica_pkg::*;
#(
    parameter int replica_num     = 32,
    parameter int run_times_w_p   = run_times_w
) ();

    logic                     run_write;
    logic [run_times_w_p-1:0] run_times;
    logic                     opt_run;
    logic [replica_num-1:0]   opt_done;
    logic                     exchange_run;
    logic                     exchange_odd;
    logic                     exchange_done;
    logic                     running;
    logic [run_times_w_p-1:0] iter_count;

    modport slave (
        input  run_write,
        input  run_times,
        input  opt_done,
        input  exchange_done,
        output opt_run,
        output exchange_run,
        output exchange_odd,
        output running,
        output iter_count
    );

    modport master (
        output run_write,
        output run_times,
        output opt_done,
        output exchange_done,
        input  opt_run,
        input  exchange_run,
        input  exchange_odd,
        input  running,
        input  iter_count
    );

endinterface

// File: rtl/replica_done_mask.sv
// Sticky per-replica completion mask; all_done also counts pulses arriving this cycle.
module replica_done_mask #(
    parameter int replica_num = 32
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   clear,
    input  logic                   accum,
    input  logic [replica_num-1:0] done_in,
    output logic                   all_done
);

    logic [replica_num-1:0] mask;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            mask <= '0;
        end else if (clear) begin
            mask <= '0;
        end else if (accum) begin
            mask <= mask | done_in;
        end
    end

    assign all_done = &(mask | done_in);

endmodule

// File: rtl/run_ctrl.sv
// Sequences optimisation / replica-exchange iterations for a host-issued run command.
//  state     | meaning
//  IDLE      | no run in progress, waiting for run_write with nonzero count
//  OPT_START | opt_run pulse, done mask cleared
//  OPT_WAIT  | collecting opt_done from every replica
//  EX_START  | exchange_run pulse
//  EX_WAIT   | waiting for exchange_done, then next iteration or finish
module run_ctrl
    import replica_pkg::*;
#(
    parameter int replica_num = 32
) (
    input  logic      S_AXI_ACLK,
    input  logic      S_AXI_ARESETN,
    run_ctrl_if.slave bus
);

    run_state_t             state;
    logic [run_times_w-1:0] remaining;
    logic [run_times_w-1:0] iter_count_q;
    logic                   abort;
    logic                   running_q;
    logic                   exchange_odd_q;
    logic                   all_done;
    logic                   run_start;
    logic                   abort_req;
    logic                   last_iter;

    assign run_start = bus.run_write && (bus.run_times != '0);
    assign abort_req = bus.run_write && (bus.run_times == '0);
    assign last_iter = (remaining == run_times_w'(1)) || abort;

    assign bus.opt_run      = (state == OPT_START);
    assign bus.exchange_run = (state == EX_START);
    assign bus.running      = running_q;
    assign bus.exchange_odd = exchange_odd_q;
    assign bus.iter_count   = iter_count_q;

    // Clearing in OPT_START also discards any opt_done seen there.
    replica_done_mask #(
        .replica_num (replica_num)
    ) u_done_mask (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .clear         (state == OPT_START),
        .accum         (state == OPT_WAIT),
        .done_in       (bus.opt_done),
        .all_done      (all_done)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state          <= IDLE;
            remaining      <= '0;
            iter_count_q   <= '0;
            abort          <= 1'b0;
            running_q      <= 1'b0;
            exchange_odd_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        state          <= OPT_START;
                        remaining      <= bus.run_times;
                        iter_count_q   <= '0;
                        exchange_odd_q <= 1'b0;
                        running_q      <= 1'b1;
                        abort          <= 1'b0;
                    end
                end
                OPT_START: state <= OPT_WAIT;
                OPT_WAIT: begin
                    if (all_done) begin
                        state <= EX_START;
                    end
                end
                EX_START: state <= EX_WAIT;
                EX_WAIT: begin
                    if (bus.exchange_done) begin
                        iter_count_q   <= iter_count_q + 1'b1;
                        remaining      <= remaining - 1'b1;
                        exchange_odd_q <= ~exchange_odd_q;
                        if (last_iter) begin
                            state     <= IDLE;
                            running_q <= 1'b0;
                        end else begin
                            state <= OPT_START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A zero-count write while busy lets the current iteration finish, then stops.
            if (state != IDLE && abort_req) begin
                abort <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: iteration sequencing, parity, staggered completion, abort, reset.
module tb_run_ctrl;
    import replica_pkg::*;

    localparam int replica_num = 32;
    localparam logic [replica_num-1:0] all_ones = '1;

    logic S_AXI_ACLK    = 1'b0;
    logic S_AXI_ARESETN = 1'b0;
    int   n_checks      = 0;
    int   n_errors      = 0;

    run_ctrl_if #(.replica_num(replica_num)) bus ();

    run_ctrl #(
        .replica_num (replica_num)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .bus           (bus)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic write_run(input logic [run_times_w-1:0] n);
        bus.run_write = 1'b1;
        bus.run_times = n;
        tick();
        bus.run_write = 1'b0;
        bus.run_times = '0;
    endtask

    task automatic pulse_opt(input logic [replica_num-1:0] m);
        bus.opt_done = m;
        tick();
        bus.opt_done = '0;
    endtask

    task automatic pulse_ex();
        bus.exchange_done = 1'b1;
        tick();
        bus.exchange_done = 1'b0;
    endtask

    // Entered in the OPT_START cycle; leaves one cycle after exchange_done.
    task automatic run_iter(input string tag, input logic exp_odd);
        tick();
        pulse_opt(all_ones);
        chk({tag, "_exrun"}, 32'(bus.exchange_run), 1);
        chk({tag, "_odd"}, 32'(bus.exchange_odd), 32'(exp_odd));
        tick();
        pulse_ex();
    endtask

    initial begin
        logic [replica_num-1:0] pat;
        logic                   seen;

        bus.run_write     = 1'b0;
        bus.run_times     = '0;
        bus.opt_done      = '0;
        bus.exchange_done = 1'b0;

        #12;
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_opt_run", 32'(bus.opt_run), 0);
        chk("rst_exrun", 32'(bus.exchange_run), 0);
        chk("rst_odd", 32'(bus.exchange_odd), 0);
        chk("rst_iter", 32'(bus.iter_count), 0);
        S_AXI_ARESETN = 1'b1;
        tick();

        // single iteration: run_write at t
        write_run(24'd1);
        chk("single_running", 32'(bus.running), 1);
        chk("single_opt_run", 32'(bus.opt_run), 1);
        repeat (4) tick();
        chk("single_no_early_ex", 32'(bus.exchange_run), 0);
        pulse_opt(all_ones);
        chk("single_exrun", 32'(bus.exchange_run), 1);
        chk("single_odd", 32'(bus.exchange_odd), 0);
        repeat (3) tick();
        chk("single_still_running", 32'(bus.running), 1);
        pulse_ex();
        chk("single_done_running", 32'(bus.running), 0);
        chk("single_iter", 32'(bus.iter_count), 1);

        // parity alternation, started in the idle cycle right after completion
        write_run(24'd3);
        chk("par_iter_reset", 32'(bus.iter_count), 0);
        for (int i = 0; i < 3; i++) begin
            chk("par_opt_run", 32'(bus.opt_run), 1);
            run_iter("par", 1'(i % 2));
        end
        chk("par_running", 32'(bus.running), 0);
        chk("par_iter", 32'(bus.iter_count), 3);
        chk("par_opt_idle", 32'(bus.opt_run), 0);

        // staggered completion: replica 31 also pulses during OPT_START, which must be ignored
        tick();
        write_run(24'd1);
        bus.opt_done = '0;
        bus.opt_done[31] = 1'b1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            chk("stag_no_early_ex", 32'(bus.exchange_run), 0);
            pat = '0;
            if (c == 20) begin
                pat[31] = 1'b1;
            end else begin
                for (int r = 0; r < 31; r++) begin
                    if (2 + (r % 18) == c) pat[r] = 1'b1;
                end
                if (c == 19) pat[0] = 1'b1;
            end
            bus.opt_done = pat;
        end
        tick();
        bus.opt_done = '0;
        chk("stag_exrun_t21", 32'(bus.exchange_run), 1);
        tick();
        pulse_ex();
        chk("stag_running", 32'(bus.running), 0);
        chk("stag_iter", 32'(bus.iter_count), 1);

        // abort during second OPT_WAIT, plus an ignored nonzero write while busy
        write_run(24'd100);
        chk("abort_running", 32'(bus.running), 1);
        run_iter("abort_it1", 1'b0);
        chk("abort_it2_start", 32'(bus.opt_run), 1);
        chk("abort_iter1", 32'(bus.iter_count), 1);
        tick();
        write_run(24'd0);
        write_run(24'd5);
        pulse_opt(all_ones);
        chk("abort_exrun", 32'(bus.exchange_run), 1);
        chk("abort_odd", 32'(bus.exchange_odd), 1);
        tick();
        pulse_ex();
        chk("abort_running_end", 32'(bus.running), 0);
        chk("abort_iter", 32'(bus.iter_count), 2);
        repeat (3) tick();
        chk("abort_no_restart", 32'(bus.opt_run), 0);

        // ignored inputs while idle
        write_run(24'd0);
        chk("idle_zero_running", 32'(bus.running), 0);
        chk("idle_zero_opt_run", 32'(bus.opt_run), 0);
        pulse_opt(all_ones);
        chk("idle_opt_done_ex", 32'(bus.exchange_run), 0);
        pulse_ex();
        tick();
        chk("idle_ex_done_running", 32'(bus.running), 0);
        chk("idle_ex_done_opt", 32'(bus.opt_run), 0);
        chk("idle_iter_held", 32'(bus.iter_count), 2);

        // reset in EX_WAIT of the second iteration
        write_run(24'd3);
        run_iter("rst_it1", 1'b0);
        tick();
        pulse_opt(all_ones);
        tick();
        #2;
        S_AXI_ARESETN = 1'b0;
        #1;
        chk("mid_rst_running", 32'(bus.running), 0);
        chk("mid_rst_odd", 32'(bus.exchange_odd), 0);
        chk("mid_rst_iter", 32'(bus.iter_count), 0);
        chk("mid_rst_exrun", 32'(bus.exchange_run), 0);
        #2;
        S_AXI_ARESETN = 1'b1;
        bus.exchange_done = 1'b1;
        tick();
        bus.exchange_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.exchange_run || bus.opt_run || bus.running) seen = 1'b1;
            tick();
        end
        chk("post_rst_quiet", 32'(seen), 0);
        write_run(24'd1);
        chk("post_rst_opt_run", 32'(bus.opt_run), 1);
        run_iter("post_rst", 1'b0);
        chk("post_rst_running", 32'(bus.running), 0);
        chk("post_rst_iter", 32'(bus.iter_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
